tmds_word_aligner: RTL and testbench
====================================

Name: tmds_word_aligner

Overview:
- Receive-side counterpart of the TMDS 10:1 transmit serializer; one instance per TMDS channel, in the clk_pixel domain, directly after the 1:10 input deserializer.
- Incoming 10-bit raw words carry an unknown bit offset; the block searches for DVI/HDMI control tokens, locks to the bit offset, and outputs realigned 10-bit TMDS characters to the downstream TMDS decoder.
- Bit 0 of every word is the first bit on the wire, matching transmit order.

Parameters:
- LOCK_HITS, 8: consecutive-equivalent control-token hits at one offset required to lock; also the mismatch count that forces unlock.
- TIMEOUT, 4096: raw_valid cycles without a token at the tracked offset before returning to SEARCH; must exceed the longest active-video run.
- CW, $clog2(TIMEOUT+1): gap counter width (derived, not overridden).

Ports:
- clk_pixel  in  1  pixel clock, the only clock.
- reset  in  1  synchronous, active-high reset.
- raw_word  in  10  unaligned deserializer word; bit 0 = earliest bit.
- raw_valid  in  1  raw_word qualifier; when low, all state and counters hold.
- word_out  out  10  aligned TMDS character.
- word_valid  out  1  high when locked and the cycle's raw_valid was high.
- locked  out  1  alignment state is LOCKED.
- offset  out  4  current or candidate bit offset, 0..9.
- ctrl_detect  out  1  word_out is a control token.
- ctrl_code  out  2  {C1,C0} of the detected token; 0 when ctrl_detect is low.

Behaviour:
- Interface: one clock (clk_pixel); reset is synchronous and active-high.
- Reset: all outputs are 0. The state machine is in SEARCH. prev word, counters and offset are 0.
- Window: on each raw_valid cycle, W = {raw_word, prev}, 20 bits, where prev is the previous valid raw_word. Candidate k (0..9) is W[k+9:k]. prev is then updated to raw_word.
- Token match: compare each candidate against 1101010100 (code 00), 0010101011 (01), 0101010100 (10) and 1010101011 (11). If several offsets hit in the same cycle, the lowest offset wins.
- SEARCH:
  - On any hit: offset <= hit offset, hit_cnt <= 1, gap <= 0, go to VERIFY.
- VERIFY:
  - Hit at offset: hit_cnt++ and gap <= 0.
  - Hit only at another offset: offset <= that offset, hit_cnt <= 1.
  - No hit: gap++.
  - hit_cnt reaching LOCK_HITS: go to LOCKED, miss_cnt <= 0.
  - gap reaching TIMEOUT: go to SEARCH.
- LOCKED:
  - Hit at offset: gap <= 0, miss_cnt <= 0.
  - Hit only at another offset: miss_cnt++.
  - Neither: gap++.
  - miss_cnt reaching LOCK_HITS, or gap reaching TIMEOUT: go to SEARCH. locked drops the next cycle and offset is retained until the next SEARCH hit.
- Output pipeline: word_out, word_valid, ctrl_detect and ctrl_code are registered. Latency is 1 cycle from the raw_valid cycle that completes the window.
  - word_out = W[offset+9:offset] using the offset in force before that cycle's update.
  - word_out holds when raw_valid is low.
- locked, offset: registered state, valid the cycle after the transition.
- Boundaries:
  - Offset 0 uses prev only. Offset 9 uses prev[9] and raw_word[8:0].
  - raw_valid low mid-search freezes everything; no gap increment.
  - Reset mid-lock returns to SEARCH in one cycle with all outputs 0.
  - Counters never wrap: hit_cnt, miss_cnt and gap saturate at their thresholds.

Optional Feature:
- Macro TMDS_ALIGN_STATS_EN.
- Defined: adds output relock_count (16-bit) and a 16-bit saturating counter. It increments on every LOCKED->SEARCH transition, is cleared by reset, and holds at 0xFFFF.
- Undefined: neither the port nor the counter exists; all other behaviour is identical.

Decomposition:
- Shared package tmds_pkg:
  - four control-token constants;
  - align_state_t enum (SEARCH, VERIFY, LOCKED);
  - TMDS_WORD_W = 10.
- Package content is shared with the transmit encoder and the future decoder.
- One sub-module, tmds_token_match: combinational compare of a 10-bit window. Outputs hit (1) and code (2). Instantiated 10 times plus once on the output path.

Test Plan:
- Reset, then a stream of token 1101010100 rotated so the wire offset is 3, raw_valid constant -> offset=3 after the first valid, locked=1 after 8 hits. word_out=1101010100 with ctrl_detect=1, ctrl_code=0.
- Locked at offset 3, then 2000 cycles of non-token data followed by token 0010101011 -> stays locked; word_out carries the data with 1-cycle latency; ctrl_code=01 on the token.
- Locked at offset 3, then 4096 valid cycles with no tokens -> locked=0 on cycle 4097; relock_count=1 when TMDS_ALIGN_STATS_EN is defined.
- Locked at offset 3, stream shifted so tokens appear at offset 7 -> unlocks after 8 mismatches, re-verifies, locked=1 with offset=7 after 8 further hits.
- raw_valid toggling 1/0 every cycle during lock-in at offset 9 -> lock takes exactly 8 valid cycles; no counter advances in invalid cycles; offset-9 window is correct.
- reset asserted for one cycle while locked -> the next cycle has locked=0, word_valid=0, word_out=0, offset=0.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token characters, alignment states and word width.
// Used by the transmit encoder, this receive aligner and the decoder.
package tmds_pkg;

  localparam int TMDS_WORD_W = 10;

  // Control tokens as 10-bit characters, bit 0 first on the wire; suffix is {C1,C0}.
  localparam logic [TMDS_WORD_W-1:0] TOKEN_C00 = 10'b1101010100;
  localparam logic [TMDS_WORD_W-1:0] TOKEN_C01 = 10'b0010101011;
  localparam logic [TMDS_WORD_W-1:0] TOKEN_C10 = 10'b0101010100;
  localparam logic [TMDS_WORD_W-1:0] TOKEN_C11 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } align_state_t;

  // Ten bits of a two-word window starting at bit k (k = 0..9).
  function automatic logic [TMDS_WORD_W-1:0] window_at(
    input logic [2*TMDS_WORD_W-1:0] w,
    input logic [3:0]               k
  );
    logic [2*TMDS_WORD_W-1:0] s;
    s = w >> k;
    return s[TMDS_WORD_W-1:0];
  endfunction

endpackage

// File: rtl/tmds_word_aligner_if.sv
// Bus between the deserializer side and the word aligner: raw words in, aligned characters
// and lock status out. relock_count exists only when TMDS_ALIGN_STATS_EN is defined.
interface tmds_word_aligner_if;

  logic [tmds_pkg::TMDS_WORD_W-1:0] raw_word;
  logic                             raw_valid;
  logic [tmds_pkg::TMDS_WORD_W-1:0] word_out;
  logic                             word_valid;
  logic                             locked;
  logic [3:0]                       offset;
  logic                             ctrl_detect;
  logic [1:0]                       ctrl_code;
`ifdef TMDS_ALIGN_STATS_EN
  logic [15:0]                      relock_count;

  modport master (
    output raw_word, raw_valid,
    input  word_out, word_valid, locked, offset, ctrl_detect, ctrl_code, relock_count
  );

  modport slave (
    input  raw_word, raw_valid,
    output word_out, word_valid, locked, offset, ctrl_detect, ctrl_code, relock_count
  );
`else
  modport master (
    output raw_word, raw_valid,
    input  word_out, word_valid, locked, offset, ctrl_detect, ctrl_code
  );

  modport slave (
    input  raw_word, raw_valid,
    output word_out, word_valid, locked, offset, ctrl_detect, ctrl_code
  );
`endif

endinterface

// File: rtl/tmds_token_match.sv
// Combinational check of one 10-bit window against the four TMDS control tokens.
// code is {C1,C0} of the matching token and 0 when there is no hit.
module tmds_token_match
  import tmds_pkg::*;
(
  input  logic [TMDS_WORD_W-1:0] window,
  output logic                   hit,
  output logic [1:0]             code
);

  always_comb begin
    hit  = 1'b1;
    code = 2'b00;
    case (window)
      TOKEN_C00: code = 2'b00;
      TOKEN_C01: code = 2'b01;
      TOKEN_C10: code = 2'b10;
      TOKEN_C11: code = 2'b11;
      default:   hit  = 1'b0;
    endcase
  end

endmodule

// File: rtl/tmds_word_aligner.sv
// TMDS receive word aligner: hunts for control tokens at all ten bit offsets, locks to the
// offset that repeats, and emits realigned characters. TMDS_ALIGN_STATS_EN adds relock_count.
module tmds_word_aligner
  import tmds_pkg::*;
#(
  parameter  int LOCK_HITS = 8,
  parameter  int TIMEOUT   = 4096,
  localparam int CW        = $clog2(TIMEOUT + 1),
  localparam int HW        = $clog2(LOCK_HITS + 1)
) (
  input logic                clk_pixel,
  input logic                reset,
  tmds_word_aligner_if.slave bus
);

  localparam logic [1:0] ST_SEARCH = SEARCH;
  localparam logic [1:0] ST_VERIFY = VERIFY;
  localparam logic [1:0] ST_LOCKED = LOCKED;

  localparam logic [HW-1:0] HIT_ONE  = HW'(1);
  localparam logic [HW-1:0] HIT_LAST = HW'(LOCK_HITS - 1);
  localparam logic [HW-1:0] HIT_FULL = HW'(LOCK_HITS);
  localparam logic [CW-1:0] GAP_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_FULL = CW'(TIMEOUT);

  logic [1:0]             state_reg,    state_next;
  logic [3:0]             offset_reg,   offset_next;
  logic [HW-1:0]          hit_cnt_reg,  hit_cnt_next;
  logic [HW-1:0]          miss_cnt_reg, miss_cnt_next;
  logic [CW-1:0]          gap_reg,      gap_next;
  logic [TMDS_WORD_W-1:0] prev_reg;

  logic [TMDS_WORD_W-1:0] word_reg;
  logic                   word_valid_reg;
  logic                   detect_reg;
  logic [1:0]             code_reg;

  logic [2*TMDS_WORD_W-1:0] window;
  logic [TMDS_WORD_W-1:0]   cand_hit;
  logic                     any_hit;
  logic [3:0]               first_off;
  logic                     hit_at_off;
  logic [TMDS_WORD_W-1:0]   word_next;
  logic                     out_hit;
  logic [1:0]               out_code;

  assign window = {bus.raw_word, prev_reg};

  // One matcher per candidate offset; only whether each hits matters here, the reported
  // code comes from the output-path matcher.
  genvar gi;
  generate
    for (gi = 0; gi < TMDS_WORD_W; gi++) begin : g_cand
      logic [1:0] code_unused;
      tmds_token_match u_match (
        .window (window[gi +: TMDS_WORD_W]),
        .hit    (cand_hit[gi]),
        .code   (code_unused)
      );
    end
  endgenerate

  // Lowest offset wins when several candidates hit together.
  always_comb begin
    first_off = 4'd0;
    for (int k = TMDS_WORD_W - 1; k >= 0; k--) begin
      if (cand_hit[k]) first_off = 4'(k);
    end
  end

  assign any_hit    = |cand_hit;
  assign hit_at_off = cand_hit[offset_reg];
  assign word_next  = window_at(window, offset_reg);

  tmds_token_match u_out_match (
    .window (word_next),
    .hit    (out_hit),
    .code   (out_code)
  );

  always_comb begin
    state_next    = state_reg;
    offset_next   = offset_reg;
    hit_cnt_next  = hit_cnt_reg;
    miss_cnt_next = miss_cnt_reg;
    gap_next      = gap_reg;
    if (bus.raw_valid) begin
      case (state_reg)
        ST_SEARCH: begin
          if (any_hit) begin
            offset_next  = first_off;
            hit_cnt_next = HIT_ONE;
            gap_next     = '0;
            state_next   = ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (hit_at_off) begin
            gap_next = '0;
            if (hit_cnt_reg >= HIT_LAST) begin
              hit_cnt_next  = HIT_FULL;
              miss_cnt_next = '0;
              state_next    = ST_LOCKED;
            end else begin
              hit_cnt_next = hit_cnt_reg + 1'b1;
            end
          end else if (any_hit) begin
            // Token moved: restart verification at the new offset.
            offset_next  = first_off;
            hit_cnt_next = HIT_ONE;
            gap_next     = '0;
          end else if (gap_reg >= GAP_LAST) begin
            gap_next   = GAP_FULL;
            state_next = ST_SEARCH;
          end else begin
            gap_next = gap_reg + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (hit_at_off) begin
            gap_next      = '0;
            miss_cnt_next = '0;
          end else if (any_hit) begin
            if (miss_cnt_reg >= HIT_LAST) begin
              miss_cnt_next = HIT_FULL;
              state_next    = ST_SEARCH;
            end else begin
              miss_cnt_next = miss_cnt_reg + 1'b1;
            end
          end else if (gap_reg >= GAP_LAST) begin
            gap_next   = GAP_FULL;
            state_next = ST_SEARCH;
          end else begin
            gap_next = gap_reg + 1'b1;
          end
        end
        default: state_next = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_reg      <= ST_SEARCH;
      offset_reg     <= '0;
      hit_cnt_reg    <= '0;
      miss_cnt_reg   <= '0;
      gap_reg        <= '0;
      prev_reg       <= '0;
      word_reg       <= '0;
      word_valid_reg <= 1'b0;
      detect_reg     <= 1'b0;
      code_reg       <= 2'b00;
    end else begin
      state_reg      <= state_next;
      offset_reg     <= offset_next;
      hit_cnt_reg    <= hit_cnt_next;
      miss_cnt_reg   <= miss_cnt_next;
      gap_reg        <= gap_next;
      word_valid_reg <= bus.raw_valid && (state_reg == ST_LOCKED);
      if (bus.raw_valid) begin
        prev_reg   <= bus.raw_word;
        word_reg   <= word_next;
        detect_reg <= out_hit;
        code_reg   <= out_code;
      end
    end
  end

  assign bus.word_out    = word_reg;
  assign bus.word_valid  = word_valid_reg;
  assign bus.locked      = (state_reg == ST_LOCKED);
  assign bus.offset      = offset_reg;
  assign bus.ctrl_detect = detect_reg;
  assign bus.ctrl_code   = code_reg;

`ifdef TMDS_ALIGN_STATS_EN
  logic [15:0] relock_reg;

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      relock_reg <= '0;
    end else if ((state_reg == ST_LOCKED) && (state_next == ST_SEARCH) && (relock_reg != 16'hFFFF)) begin
      relock_reg <= relock_reg + 16'd1;
    end
  end

  assign bus.relock_count = relock_reg;
`endif

endmodule

// File: tb/tb_tmds_word_aligner.sv
// Self-checking bench for tmds_word_aligner: a rule-level model checked every cycle plus
// hand-computed expectations at the points of interest.
module tb_tmds_word_aligner;

  localparam int LOCK = 8;
  localparam int TO   = 4096;

  localparam logic [9:0] TK00 = 10'b1101010100;
  localparam logic [9:0] TK01 = 10'b0010101011;

  localparam int M_SEARCH = 0;
  localparam int M_VERIFY = 1;
  localparam int M_LOCKED = 2;

  logic clk_pixel = 1'b0;
  logic reset;
  always #5 clk_pixel = ~clk_pixel;

  tmds_word_aligner_if bus ();

  tmds_word_aligner dut (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .bus       (bus)
  );

  int n_checks;
  int n_fail;
  bit cmp_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // {hit, code} of a 10-bit character against the four control tokens.
  function automatic logic [2:0] lookup(input logic [9:0] c);
    case (c)
      10'b1101010100: return 3'b100;
      10'b0010101011: return 3'b101;
      10'b0101010100: return 3'b110;
      10'b1010101011: return 3'b111;
      default:        return 3'b000;
    endcase
  endfunction

  // Word that, sent repeatedly, places token t at bit offset k of the window.
  function automatic logic [9:0] rot(input logic [9:0] t, input int k);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[(k + i) % 10] = t[i];
    return r;
  endfunction

  // Pair-doubled data never holds an alternating run of three, so it never forms a token.
  function automatic logic [9:0] dbl(input logic [4:0] d);
    logic [9:0] r;
    for (int i = 0; i < 5; i++) begin
      r[2*i]     = d[i];
      r[2*i + 1] = d[i];
    end
    return r;
  endfunction

  // ---------------- behavioural model ----------------
  int         m_state, m_off, m_hits, m_miss, m_gap, m_first, m_relock;
  logic [9:0] m_prev, m_word;
  logic       m_wvalid, m_det;
  logic [1:0] m_code;
  logic [19:0] mw;
  bit          mhit [10];
  bit          m_at;
  logic [2:0]  lk;

  always @(posedge clk_pixel) begin
    if (reset) begin
      m_state = M_SEARCH; m_off = 0; m_hits = 0; m_miss = 0; m_gap = 0; m_relock = 0;
      m_prev = '0; m_word = '0; m_wvalid = 1'b0; m_det = 1'b0; m_code = 2'b00;
    end else if (!bus.raw_valid) begin
      m_wvalid = 1'b0;
    end else begin
      mw = {bus.raw_word, m_prev};
      m_first = -1;
      for (int k = 9; k >= 0; k--) begin
        lk = lookup(10'(mw >> k));
        mhit[k] = lk[2];
        if (lk[2]) m_first = k;
      end
      m_at     = mhit[m_off];
      m_word   = 10'(mw >> m_off);
      lk       = lookup(m_word);
      m_det    = lk[2];
      m_code   = lk[1:0];
      m_wvalid = (m_state == M_LOCKED);
      m_prev   = bus.raw_word;
      case (m_state)
        M_SEARCH: if (m_first >= 0) begin
          m_off = m_first; m_hits = 1; m_gap = 0; m_state = M_VERIFY;
        end
        M_VERIFY: begin
          if (m_at) begin
            m_gap = 0;
            m_hits = (m_hits + 1 > LOCK) ? LOCK : m_hits + 1;
            if (m_hits == LOCK) begin m_state = M_LOCKED; m_miss = 0; end
          end else if (m_first >= 0) begin
            m_off = m_first; m_hits = 1; m_gap = 0;
          end else begin
            m_gap = (m_gap + 1 > TO) ? TO : m_gap + 1;
            if (m_gap == TO) m_state = M_SEARCH;
          end
        end
        default: begin
          if (m_at) begin
            m_gap = 0; m_miss = 0;
          end else if (m_first >= 0) begin
            m_miss = (m_miss + 1 > LOCK) ? LOCK : m_miss + 1;
            if (m_miss == LOCK) m_state = M_SEARCH;
          end else begin
            m_gap = (m_gap + 1 > TO) ? TO : m_gap + 1;
            if (m_gap == TO) m_state = M_SEARCH;
          end
          if (m_state == M_SEARCH && m_relock < 65535) m_relock++;
        end
      endcase
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk_pixel) begin
    if (cmp_en) begin
      check("cyc_locked",      32'(bus.locked),      32'(m_state == M_LOCKED));
      check("cyc_offset",      32'(bus.offset),      32'(m_off));
      check("cyc_word_valid",  32'(bus.word_valid),  32'(m_wvalid));
      check("cyc_word_out",    32'(bus.word_out),    32'(m_word));
      check("cyc_ctrl_detect", 32'(bus.ctrl_detect), 32'(m_det));
      check("cyc_ctrl_code",   32'(bus.ctrl_code),   32'(m_code));
`ifdef TMDS_ALIGN_STATS_EN
      check("cyc_relock",      32'(bus.relock_count), 32'(m_relock));
`endif
    end
  end

  task automatic drive(input logic [9:0] w, input logic v);
    bus.raw_word  = w;
    bus.raw_valid = v;
    @(negedge clk_pixel);
  endtask

  logic [9:0] r3, r7, r9, r01;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cmp_en   = 1'b0;
    reset    = 1'b1;
    bus.raw_word  = '0;
    bus.raw_valid = 1'b0;
    r3  = rot(TK00, 3);
    r7  = rot(TK00, 7);
    r9  = rot(TK00, 9);
    r01 = rot(TK01, 3);
    repeat (2) @(negedge clk_pixel);
    cmp_en = 1'b1;

    check("rst_locked",     32'(bus.locked),     32'd0);
    check("rst_offset",     32'(bus.offset),     32'd0);
    check("rst_word_out",   32'(bus.word_out),   32'd0);
    check("rst_word_valid", 32'(bus.word_valid), 32'd0);
    check("rst_ctrl",       32'({bus.ctrl_detect, bus.ctrl_code}), 32'd0);
    reset = 1'b0;

    // Lock-in at offset 3: the first word only fills prev, then 8 hits lock.
    drive(r3, 1'b1);
    check("lk3_first_offset", 32'(bus.offset), 32'd0);
    drive(r3, 1'b1);
    check("lk3_offset", 32'(bus.offset), 32'd3);
    repeat (6) drive(r3, 1'b1);
    check("lk3_not_yet", 32'(bus.locked), 32'd0);
    drive(r3, 1'b1);
    check("lk3_locked", 32'(bus.locked), 32'd1);
    drive(r3, 1'b1);
    check("lk3_word",  32'(bus.word_out),    32'(TK00));
    check("lk3_det",   32'(bus.ctrl_detect), 32'd1);
    check("lk3_code",  32'(bus.ctrl_code),   32'd0);
    check("lk3_valid", 32'(bus.word_valid),  32'd1);

    // Long data run with no tokens, then a code-01 token.
    for (int i = 0; i < 2000; i++) drive(dbl(5'($urandom)), 1'b1);
    drive(10'h3FF, 1'b1);
    drive(10'h000, 1'b1);
    check("data_word",   32'(bus.word_out), 32'h07F);
    check("data_locked", 32'(bus.locked),   32'd1);
    drive(r01, 1'b1);
    drive(r01, 1'b1);
    check("tok01_word", 32'(bus.word_out),    32'(TK01));
    check("tok01_det",  32'(bus.ctrl_detect), 32'd1);
    check("tok01_code", 32'(bus.ctrl_code),   32'd1);

    // Timeout: 4096 token-free valid words.
    repeat (TO - 1) drive(10'h000, 1'b1);
    check("gap_still_locked", 32'(bus.locked), 32'd1);
    drive(10'h000, 1'b1);
    check("gap_unlocked", 32'(bus.locked), 32'd0);
    check("gap_offset_kept", 32'(bus.offset), 32'd3);
`ifdef TMDS_ALIGN_STATS_EN
    check("gap_relock", 32'(bus.relock_count), 32'd1);
`endif

    // Relock at 3, then tokens move to offset 7.
    repeat (10) drive(r3, 1'b1);
    check("re3_locked", 32'(bus.locked), 32'd1);
    check("re3_offset", 32'(bus.offset), 32'd3);
    repeat (3) drive(r7, 1'b1);
    check("mv7_hold_locked", 32'(bus.locked), 32'd1);
    check("mv7_hold_offset", 32'(bus.offset), 32'd3);
    repeat (17) drive(r7, 1'b1);
    check("mv7_locked", 32'(bus.locked), 32'd1);
    check("mv7_offset", 32'(bus.offset), 32'd7);
`ifdef TMDS_ALIGN_STATS_EN
    check("mv7_relock", 32'(bus.relock_count), 32'd2);
`endif

    // One-cycle reset while locked.
    reset = 1'b1;
    drive(r7, 1'b1);
    reset = 1'b0;
    check("rl_locked",     32'(bus.locked),     32'd0);
    check("rl_word_valid", 32'(bus.word_valid), 32'd0);
    check("rl_word_out",   32'(bus.word_out),   32'd0);
    check("rl_offset",     32'(bus.offset),     32'd0);

    // Offset 9 lock-in with raw_valid alternating; invalid words carry junk.
    for (int i = 0; i < 7; i++) begin
      drive(r9, 1'b1);
      drive(10'h155, 1'b0);
    end
    check("o9_not_yet", 32'(bus.locked), 32'd0);
    check("o9_offset",  32'(bus.offset), 32'd9);
    drive(r9, 1'b1);
    check("o9_locked", 32'(bus.locked), 32'd1);
    drive(10'h2AA, 1'b0);
    check("o9_hold_locked", 32'(bus.locked), 32'd1);
    drive(r9, 1'b1);
    drive(r9, 1'b1);
    check("o9_word",  32'(bus.word_out),   32'(TK00));
    check("o9_valid", 32'(bus.word_valid), 32'd1);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
